// File: rtl/uart_dbg_pkg.sv
// Shared definitions for the UART debug sequencer: FSM encoding,
// default command/header bytes and the frame length helper.
package uart_dbg_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_RUN    = 3'd2,
        S_STEP   = 3'd3,
        S_SEND   = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    localparam logic [7:0] DEF_CMD_RUN  = 8'h63; // 'c'
    localparam logic [7:0] DEF_CMD_STEP = 8'h73; // 's'
    localparam logic [7:0] DEF_CMD_DUMP = 8'h64; // 'd'
    localparam logic [7:0] DEF_HDR_BYTE = 8'hA5;

    // Header byte + NWORDS 32-bit words + 32-bit cycle count.
    function automatic int unsigned frame_len(input int unsigned nwords);
        return 1 + 4 * nwords + 4;
    endfunction

endpackage

// File: rtl/dbg_frame_mux.sv
// Byte selector for the dump frame: maps the frame index onto the
// header, the debug words (MSB first) or the cycle count (MSB first).
module dbg_frame_mux
    import uart_dbg_pkg::*;
#(
    parameter int unsigned NWORDS   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned IDX_W    = 8,
    parameter logic [7:0]  HDR_BYTE = DEF_HDR_BYTE
) (
    input  logic              en_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [31:0]       dump_data_i,
    input  logic [31:0]       cyc_cnt_i,
    output logic [7:0]        w_data_o,
    output logic [ADDR_W-1:0] dump_addr_o
);

    localparam logic [IDX_W-1:0] WORD_END = IDX_W'(4 * NWORDS);
    localparam logic [IDX_W-1:0] CYC_BASE = IDX_W'(4 * NWORDS + 1);

    logic [IDX_W-1:0] off;
    logic [1:0]       cyc_b;

    // Select the frame byte for the current index; outputs rest at zero outside a frame.
    always_comb begin
        w_data_o    = '0;
        dump_addr_o = '0;
        off         = idx_i - IDX_W'(1);
        cyc_b       = 2'(idx_i - CYC_BASE);
        if (en_i) begin
            if (idx_i == '0) begin
                w_data_o = HDR_BYTE;
            end else if (idx_i <= WORD_END) begin
                dump_addr_o = ADDR_W'(off >> 2);
                // byte 0 of a word is bits 31:24, so shift by 8*(3-b)
                w_data_o    = 8'(dump_data_i >> {~off[1:0], 3'b000});
            end else begin
                w_data_o    = 8'(cyc_cnt_i >> {~cyc_b, 3'b000});
            end
        end
    end

endmodule

// File: rtl/uart_dbg_ctrl.sv
// Debug-unit sequencer: pops a command byte from the UART RX FIFO, runs or
// single-steps the pipeline, then streams a dump frame into the TX FIFO.
module uart_dbg_ctrl
    import uart_dbg_pkg::*;
#(
    parameter int unsigned NWORDS   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter logic [7:0]  CMD_RUN  = DEF_CMD_RUN,
    parameter logic [7:0]  CMD_STEP = DEF_CMD_STEP,
    parameter logic [7:0]  CMD_DUMP = DEF_CMD_DUMP,
    parameter logic [7:0]  HDR_BYTE = DEF_HDR_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_empty,
    input  logic [7:0]        r_data,
    output logic              rd_uart,
    input  logic              tx_full,
    output logic [7:0]        w_data,
    output logic              wr_uart,
    input  logic              halted,
    output logic              pipe_en,
    output logic [ADDR_W-1:0] dump_addr,
    input  logic [31:0]       dump_data,
    output logic              busy
);

    localparam int unsigned      TOTAL    = frame_len(NWORDS);
    localparam int unsigned      IDX_W    = $clog2(TOTAL);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TOTAL - 1);

    state_t           state_q, state_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      cyc_q, cyc_d;
    logic             live_q;
    logic             frame_en;

    // State, command, frame index and cycle counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            idx_q   <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            idx_q   <= idx_d;
            cyc_q   <= cyc_d;
        end
    end

    // Arms the RX pop one clock after reset so rd_uart stays quiet while
    // reset is held, even with bytes already waiting in the RX FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end

    // Next-state logic, FIFO handshakes, pipeline enable and cycle count.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        idx_d   = idx_q;
        cyc_d   = cyc_q;
        rd_uart = 1'b0;
        wr_uart = 1'b0;
        pipe_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_empty && live_q) begin
                    rd_uart = 1'b1;
                    cmd_d   = r_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (cmd_q == CMD_RUN) begin
                    state_d = S_RUN;
                end else if (cmd_q == CMD_STEP) begin
                    state_d = S_STEP;
                end else if (cmd_q == CMD_DUMP) begin
                    idx_d   = '0;
                    state_d = S_SEND;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                pipe_en = ~halted;
                if (halted) begin
                    idx_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_STEP: begin
                pipe_en = ~halted;
                idx_d   = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (!tx_full) begin
                    wr_uart = 1'b1;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                // one idle cycle lets the FIFO full flag catch up with the last push
                if (idx_q == IDX_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_SEND;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (pipe_en && (cyc_q != '1)) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign frame_en = (state_q == S_SEND) || (state_q == S_GAP);

    dbg_frame_mux #(
        .NWORDS   (NWORDS),
        .ADDR_W   (ADDR_W),
        .IDX_W    (IDX_W),
        .HDR_BYTE (HDR_BYTE)
    ) u_frame_mux (
        .en_i        (frame_en),
        .idx_i       (idx_q),
        .dump_data_i (dump_data),
        .cyc_cnt_i   (cyc_q),
        .w_data_o    (w_data),
        .dump_addr_o (dump_addr)
    );

endmodule

// File: tb/tb_uart_dbg_ctrl.sv
// Directed bench for uart_dbg_ctrl with a TX byte scoreboard.
module tb_uart_dbg_ctrl;

    localparam int unsigned NW = 2;
    localparam int unsigned AW = 5;
    localparam int          FL = 13;
    localparam logic [31:0] W0 = 32'h11223344;
    localparam logic [31:0] W1 = 32'hAABBCCDD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_empty;
    logic [7:0]    r_data;
    logic          rd_uart;
    logic          tx_full = 1'b0;
    logic [7:0]    w_data;
    logic          wr_uart;
    logic          halted = 1'b0;
    logic          pipe_en;
    logic [AW-1:0] dump_addr;
    logic [31:0]   dump_data;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int pipe_cnt = 0;
    logic [7:0] exp_q[$];

    logic [7:0] rx_mem [16];
    int rp = 0;
    int wp = 0;

    always #5 clk = ~clk;

    assign rx_empty  = (rp == wp);
    assign r_data    = rx_mem[rp[3:0]];
    assign dump_data = (dump_addr == 5'd0) ? W0 :
                       (dump_addr == 5'd1) ? W1 : 32'hDEADBEEF;

    always @(posedge clk) begin
        if (rd_uart) rp <= rp + 1;
    end

    uart_dbg_ctrl #(.NWORDS(NW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_empty  (rx_empty),
        .r_data    (r_data),
        .rd_uart   (rd_uart),
        .tx_full   (tx_full),
        .w_data    (w_data),
        .wr_uart   (wr_uart),
        .halted    (halted),
        .pipe_en   (pipe_en),
        .dump_addr (dump_addr),
        .dump_data (dump_data),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int unsigned i);
        logic [31:0] s;
        s = w >> (8 * (3 - i));
        return s[7:0];
    endfunction

    task automatic push_frame(input logic [31:0] cyc);
        exp_q.push_back(8'hA5);
        for (int unsigned i = 0; i < 4; i++) exp_q.push_back(byte_of(W0, i));
        for (int unsigned i = 0; i < 4; i++) exp_q.push_back(byte_of(W1, i));
        for (int unsigned i = 0; i < 4; i++) exp_q.push_back(byte_of(cyc, i));
    endtask

    task automatic push_rx(input logic [7:0] b);
        rx_mem[wp[3:0]] = b;
        wp = wp + 1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || busy || rp != wp) && n < 3000);
        check({tag, "_done"}, 32'(n < 3000), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_wr(input int target);
        int n;
        n = 0;
        while (wr_count < target && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("wait_wr", wr_count, target);
    endtask

    // Monitor: samples one time unit before each rising edge.
    int cyc_n = 0;
    int last_wr = 0;
    int pos = 0;
    bit full_since = 1'b0;
    always begin
        @(negedge clk);
        #4;
        if (rst) begin
            pos = 0;
            full_since = 1'b0;
        end else begin
            if (tx_full) full_since = 1'b1;
            if (pipe_en) pipe_cnt++;
            if (rd_uart) begin
                check("rd_in_idle", 32'(busy), 32'd0);
                check("rd_nonempty", 32'(rx_empty), 32'd0);
                check("rd_after_frame", exp_q.size() % FL, 32'd0);
            end
            if (wr_uart) begin
                check("wr_not_full", 32'(tx_full), 32'd0);
                check("rd_wr_excl", 32'(rd_uart), 32'd0);
                check("pipe_in_send", 32'(pipe_en), 32'd0);
                check("tx_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check("tx_byte", 32'(w_data), 32'(exp_q.pop_front()));
                if (pos != 0 && !full_since) check("tx_spacing", cyc_n - last_wr, 32'd2);
                last_wr = cyc_n;
                full_since = 1'b0;
                pos = (pos + 1) % FL;
                wr_count++;
            end
        end
        cyc_n++;
    end

    int base;
    int n;

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_rd", 32'(rd_uart), 32'd0);
        check("rst_wr", 32'(wr_uart), 32'd0);
        check("rst_pipe", 32'(pipe_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wdata", 32'(w_data), 32'd0);
        check("rst_addr", 32'(dump_addr), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // dump only
        push_frame(32'd0);
        push_rx(8'h64);
        wait_idle("dump");
        check("dump_count", wr_count, FL);

        // run until halt after 10 enabled cycles
        push_frame(32'd10);
        push_rx(8'h63);
        n = 0;
        while (pipe_cnt < 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        halted = 1'b1;
        wait_idle("run");
        check("run_pipe_cycles", pipe_cnt, 10);

        // single step
        halted = 1'b0;
        push_frame(32'd11);
        push_rx(8'h73);
        wait_idle("step");
        check("step_pipe_cycles", pipe_cnt, 11);

        // single step while halted
        halted = 1'b1;
        push_frame(32'd11);
        push_rx(8'h73);
        wait_idle("step_halted");
        check("step_halted_cycles", pipe_cnt, 11);

        // TX FIFO full for 20 cycles during byte 3
        base = wr_count;
        push_frame(32'd11);
        push_rx(8'h64);
        wait_wr(base + 3);
        tx_full = 1'b1;
        repeat (20) @(negedge clk);
        check("stall_no_wr", wr_count, base + 3);
        tx_full = 1'b0;
        wait_idle("stall");
        check("stall_count", wr_count, base + FL);

        // unknown byte dropped, then dump
        base = wr_count;
        push_frame(32'd11);
        push_rx(8'h78);
        push_rx(8'h64);
        wait_idle("drop");
        check("drop_count", wr_count, base + FL);
        check("drop_popped", rp, wp);

        // two dumps back to back
        base = wr_count;
        push_frame(32'd11);
        push_frame(32'd11);
        push_rx(8'h64);
        push_rx(8'h64);
        wait_idle("two");
        check("two_count", wr_count, base + 2 * FL);

        // reset during byte 5
        base = wr_count;
        push_frame(32'd11);
        push_rx(8'h64);
        wait_wr(base + 5);
        rst = 1'b1;
        #1;
        check("mid_rst_rd", 32'(rd_uart), 32'd0);
        check("mid_rst_wr", 32'(wr_uart), 32'd0);
        check("mid_rst_pipe", 32'(pipe_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_wdata", 32'(w_data), 32'd0);
        check("mid_rst_addr", 32'(dump_addr), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        base = wr_count;
        push_frame(32'd0);
        push_rx(8'h64);
        wait_idle("post_rst");
        check("post_rst_count", wr_count, base + FL);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_dbg_ctrl.md
Name: uart_dbg_ctrl

Overview:
- Debug-unit sequencer between the UART block (FIFO-side handshake) and the pipelined CPU.
- Pops one command byte from the RX FIFO and runs the pipeline to halt, single-steps it, or only dumps.
- Then streams a fixed-format frame through the TX FIFO: header byte, NWORDS 32-bit debug words, 32-bit pipeline cycle count.
- Sole owner of the UART FIFO handshakes and of the pipeline enable.

Parameters:
- NWORDS, 32: number of 32-bit debug words per dump frame; must be ≥1.
- ADDR_W, 5: width of dump_addr; 2**ADDR_W ≥ NWORDS.
- CMD_RUN, 8'h63 ('c'): command byte for run-until-halt.
- CMD_STEP, 8'h73 ('s'): command byte for single step.
- CMD_DUMP, 8'h64 ('d'): command byte for dump only.
- HDR_BYTE, 8'hA5: first byte of every frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx_empty  in  1  RX FIFO empty.
- r_data  in  8  RX FIFO head byte; valid while rx_empty=0.
- rd_uart  out  1  RX FIFO pop strobe.
- tx_full  in  1  TX FIFO full.
- w_data  out  8  byte to TX FIFO.
- wr_uart  out  1  TX FIFO push strobe.
- halted  in  1  pipeline has reached halt.
- pipe_en  out  1  pipeline advance enable.
- dump_addr  out  ADDR_W  debug word index.
- dump_data  in  32  debug word at dump_addr; combinational and stable while pipe_en=0.
- busy  out  1  command in progress (state≠IDLE).

Behaviour:
- Reset (async, any state): state=IDLE, cmd=0, idx=0, cyc_cnt=0; rd_uart, wr_uart, pipe_en, busy, w_data, dump_addr all 0. Reset mid-frame abandons the frame; bytes already pushed stay in the FIFO.
- States: IDLE, DECODE, RUN, STEP, SEND, GAP.
- IDLE:
  - If rx_empty=0: rd_uart=1 for exactly this cycle, cmd<=r_data, go to DECODE.
  - Else stay. No other output active.
- DECODE (1 cycle):
  - CMD_RUN→RUN.
  - CMD_STEP→STEP.
  - CMD_DUMP→SEND with idx<=0.
  - Any other byte→IDLE; the byte is silently dropped.
- RUN:
  - pipe_en = ~halted (combinational).
  - When halted=1 → SEND with idx<=0.
  - If halted is already 1 on entry, zero pipe_en cycles occur.
- STEP (1 cycle):
  - pipe_en = ~halted, so exactly one enable cycle unless halted.
  - Then → SEND with idx<=0.
- cyc_cnt: 32-bit; +1 every cycle pipe_en=1; saturates at 32'hFFFFFFFF; cleared only by reset.
- Frame: TOTAL = 1 + 4*NWORDS + 4 bytes, indexed by idx.
  - idx=0: HDR_BYTE.
  - idx=1..4*NWORDS: word w=(idx-1)>>2, byte b=(idx-1)&3, with b=0 the MSB (bits 31:24).
  - Last 4 bytes: cyc_cnt, MSB first.
  - dump_addr = w while idx is in the word range, else 0.
  - w_data is combinational from idx, dump_data and cyc_cnt.
- SEND:
  - If tx_full=0: wr_uart=1 for this cycle → GAP.
  - Else wait with wr_uart=0; no byte is lost or duplicated.
- GAP (1 cycle):
  - No write. This absorbs the one-cycle latency of the TX FIFO full flag.
  - If idx=TOTAL-1 → IDLE, else idx<=idx+1 → SEND.
- Throughput: at most one byte per 2 cycles.
- Commands arriving while busy stay in the RX FIFO and are handled in order after return to IDLE. There is never a pop outside IDLE.
- rd_uart and wr_uart are never both 1. pipe_en is never 1 in SEND or GAP.

Decomposition:
- Package uart_dbg_pkg: state encoding (3 bits), command byte constants, HDR_BYTE, function frame_len(NWORDS).
- One natural sub-module, dbg_frame_mux: combinational byte selection from idx, dump_data and cyc_cnt, producing w_data and dump_addr.
- FSM, idx counter and cyc_cnt stay in the top module.

Test Plan:
- Reset, then push 'd' with NWORDS=2, dump_data=32'h11223344 at word 0 and 32'hAABBCCDD at word 1, tx_full=0.
  - Required: TX byte sequence A5 11 22 33 44 AA BB CC DD 00 00 00 00.
  - Required: wr_uart pulses spaced 2 cycles apart; busy low after the last byte.
- Push 'c' with halted rising 10 cycles after RUN entry.
  - Required: pipe_en high exactly 10 cycles.
  - Required: frame ends 00 00 00 0A.
  - Then push 's': one pipe_en cycle; count bytes 00 00 00 0B.
- Push 's' while halted=1.
  - Required: no pipe_en pulse; frame is sent; count unchanged.
- Hold tx_full=1 for 20 cycles during byte 3 of a frame.
  - Required: no wr_uart while full; after release the sequence continues without gaps, loss or duplication.
- Push 'x' followed by 'd'.
  - Required: 'x' popped and dropped with no TX activity; 'd' produces a full frame.
  - Push two 'd' back-to-back: second popped only after the first frame completes.
- Assert rst in the middle of byte 5 of a frame.
  - Required: all outputs 0 asynchronously and state IDLE.
  - Required: next 'd' produces a full frame with count bytes 00 00 00 00.
